// File: rtl/contador_pkg.sv
// Shared constants for the RTC edit-path field counters.
// Field selector codes, per-field count ranges, selector width.
package contador_pkg;

  localparam int EN_W = 4;

  localparam logic [EN_W-1:0] SEL_SEG     = 4'd1;
  localparam logic [EN_W-1:0] SEL_MIN     = 4'd2;
  localparam logic [EN_W-1:0] SEL_HORA    = 4'd3;
  localparam logic [EN_W-1:0] SEL_DIA     = 4'd4;
  localparam logic [EN_W-1:0] SEL_MES     = 4'd5;
  localparam logic [EN_W-1:0] SEL_ANO     = 4'd6;
  localparam logic [EN_W-1:0] SEL_DIA_SEM = 4'd7;

  localparam int SEG_MIN     = 0;
  localparam int SEG_MAX     = 59;
  localparam int MIN_MIN     = 0;
  localparam int MIN_MAX     = 59;
  localparam int HORA_MIN    = 0;
  localparam int HORA_MAX    = 23;
  localparam int DIA_MIN     = 1;
  localparam int DIA_MAX     = 31;
  localparam int MES_MIN     = 1;
  localparam int MES_MAX     = 12;
  localparam int ANO_MIN     = 0;
  localparam int ANO_MAX     = 99;
  localparam int DIA_SEM_MIN = 0;
  localparam int DIA_SEM_MAX = 6;

endpackage

// File: rtl/detector_flanco_rpt.sv
// Key edge detector with optional autorepeat (CONTADOR_AUTOREPEAT_EN).
// Ports: clk, reset, key, active, other_key in; tick out.
module detector_flanco_rpt
  import contador_pkg::*;
#(
  parameter int HOLD_CYC = 50000000,
  parameter int RPT_CYC  = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  input  logic active,
  input  logic other_key,
  output logic tick
);

  logic r_key;
  logic w_edge;

  // Tracks the key every cycle so a key held while the
  // selector changes never looks like a fresh press.
  always_ff @(posedge clk) begin
    r_key <= key;
  end

  assign w_edge = key & ~r_key;

`ifdef CONTADOR_AUTOREPEAT_EN
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int RW = $clog2(RPT_CYC + 1);

  logic [HW-1:0] r_hold;
  logic [RW-1:0] r_rpt;
  logic          w_run;
  logic          w_held;
  logic          w_rpt;

  assign w_run  = key & active & ~other_key;
  assign w_held = (r_hold == HW'(HOLD_CYC));

  // r_hold saturates at HOLD_CYC; r_rpt then cycles
  // 0..RPT_CYC-1 and a repeat fires each time it is 0.
  always_ff @(posedge clk) begin
    if (reset || !w_run) begin
      r_hold <= '0;
      r_rpt  <= '0;
    end else begin
      if (!w_held)
        r_hold <= r_hold + HW'(1);
      if (!w_held || r_rpt == RW'(RPT_CYC - 1))
        r_rpt <= '0;
      else
        r_rpt <= r_rpt + RW'(1);
    end
  end

  assign w_rpt = w_run & w_held & (r_rpt == '0);
  assign tick  = w_edge | w_rpt;
`else
  logic unused_cfg;
  assign unused_cfg = ^{reset, active, other_key,
                        HOLD_CYC, RPT_CYC};
  assign tick = w_edge;
`endif

endmodule

// File: rtl/contador_ad_mod.sv
// Up/down modular counter for one RTC edit field; autorepeat
// via CONTADOR_AUTOREPEAT_EN. Ports: clk, reset, en_count,
// enUP, enDOWN, load_en, load_data in; count_data, carry,
// borrow, range_err out.
module contador_ad_mod
  import contador_pkg::*;
#(
  parameter int N          = 8,
  parameter int MIN        = 0,
  parameter int MAX        = 59,
  parameter int SEL_ID     = 7,
  parameter int OUT_OFFSET = 0,
  parameter int HOLD_CYC   = 50000000,
  parameter int RPT_CYC    = 10000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [EN_W-1:0] en_count,
  input  logic            enUP,
  input  logic            enDOWN,
  input  logic            load_en,
  input  logic [N-1:0]    load_data,
  output logic [N-1:0]    count_data,
  output logic            carry,
  output logic            borrow,
  output logic            range_err
);

  localparam logic [N-1:0] MIN_V = N'(MIN);
  localparam logic [N-1:0] MAX_V = N'(MAX);
  localparam logic [N-1:0] OFF_V = N'(OUT_OFFSET);

  logic [N-1:0] r_q;
  logic         r_carry;
  logic         r_borrow;
  logic         r_rerr;

  logic [N-1:0] w_q_nxt;
  logic         w_carry;
  logic         w_borrow;
  logic         w_rerr;
  logic         w_active;
  logic         w_up_t;
  logic         w_dn_t;
  logic         w_up;
  logic         w_dn;
  logic         w_lo_ok;
  logic         w_hi_ok;

  assign w_active = (en_count == EN_W'(SEL_ID));

  detector_flanco_rpt #(
    .HOLD_CYC (HOLD_CYC),
    .RPT_CYC  (RPT_CYC)
  ) u_up (
    .clk       (clk),
    .reset     (reset),
    .key       (enUP),
    .active    (w_active),
    .other_key (enDOWN),
    .tick      (w_up_t)
  );

  detector_flanco_rpt #(
    .HOLD_CYC (HOLD_CYC),
    .RPT_CYC  (RPT_CYC)
  ) u_dn (
    .clk       (clk),
    .reset     (reset),
    .key       (enDOWN),
    .active    (w_active),
    .other_key (enUP),
    .tick      (w_dn_t)
  );

  assign w_up = w_active & w_up_t;
  assign w_dn = w_active & w_dn_t;

  // Bounds at the ends of the N-bit range are always met;
  // folding them avoids constant comparisons.
  generate
    if (MIN == 0) begin : g_lo_free
      assign w_lo_ok = 1'b1;
    end else begin : g_lo_cmp
      assign w_lo_ok = (load_data >= MIN_V);
    end
    if (MAX == (1 << N) - 1) begin : g_hi_free
      assign w_hi_ok = 1'b1;
    end else begin : g_hi_cmp
      assign w_hi_ok = (load_data <= MAX_V);
    end
  endgenerate

  always_comb begin
    w_q_nxt  = r_q;
    w_carry  = 1'b0;
    w_borrow = 1'b0;
    w_rerr   = 1'b0;
    if (load_en) begin
      if (w_lo_ok && w_hi_ok) begin
        w_q_nxt = load_data;
      end else begin
        w_q_nxt = MIN_V;
        w_rerr  = 1'b1;
      end
    end else if (w_up && w_dn) begin
      w_q_nxt = r_q;
    end else if (w_up) begin
      if (r_q == MAX_V) begin
        w_q_nxt = MIN_V;
        w_carry = 1'b1;
      end else begin
        w_q_nxt = r_q + N'(1);
      end
    end else if (w_dn) begin
      if (r_q == MIN_V) begin
        w_q_nxt  = MAX_V;
        w_borrow = 1'b1;
      end else begin
        w_q_nxt = r_q - N'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q      <= MIN_V;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      r_rerr   <= 1'b0;
    end else begin
      r_q      <= w_q_nxt;
      r_carry  <= w_carry;
      r_borrow <= w_borrow;
      r_rerr   <= w_rerr;
    end
  end

  assign count_data = r_q + OFF_V;
  assign carry      = r_carry;
  assign borrow     = r_borrow;
  assign range_err  = r_rerr;

endmodule

// File: tb/tb_contador_ad_mod.sv
// Bench for contador_ad_mod: a day-of-week instance (A) and a
// 0..59 instance with fast autorepeat timing (B).
module tb_contador_ad_mod;
  import contador_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic [EN_W-1:0] en_count;
  logic            enUP_a, enDOWN_a, load_en_a;
  logic            enUP_b, enDOWN_b, load_en_b;
  logic [7:0]      load_data_a, load_data_b;
  logic [7:0]      cnt_a, cnt_b;
  logic            c_a, b_a, r_a, c_b, b_b, r_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [7:0] cnt;
    logic       c;
    logic       b;
    logic       r;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  contador_ad_mod #(
    .N(8), .MIN(0), .MAX(6), .SEL_ID(7), .OUT_OFFSET(1)
  ) dut_a (
    .clk(clk), .reset(reset), .en_count(en_count),
    .enUP(enUP_a), .enDOWN(enDOWN_a),
    .load_en(load_en_a), .load_data(load_data_a),
    .count_data(cnt_a), .carry(c_a), .borrow(b_a),
    .range_err(r_a)
  );

  contador_ad_mod #(
    .N(8), .MIN(0), .MAX(59), .SEL_ID(7), .OUT_OFFSET(0),
    .HOLD_CYC(10), .RPT_CYC(4)
  ) dut_b (
    .clk(clk), .reset(reset), .en_count(en_count),
    .enUP(enUP_b), .enDOWN(enDOWN_b),
    .load_en(load_en_b), .load_data(load_data_b),
    .count_data(cnt_b), .carry(c_b), .borrow(b_b),
    .range_err(r_b)
  );

  task automatic push_a(input string t, input int n,
                        input logic c, b, r);
    exp_t e;
    e = '{t, 8'(n), c, b, r};
    qa.push_back(e);
  endtask

  task automatic push_b(input string t, input int n,
                        input logic c, b, r);
    exp_t e;
    e = '{t, 8'(n), c, b, r};
    qb.push_back(e);
  endtask

  task automatic chk(input string inst, input exp_t e,
                     input logic [7:0] n,
                     input logic c, b, r);
    checks++;
    assert (n === e.cnt) else begin
      errors++;
      $error("FAIL %s.%s count got=%0d want=%0d",
             inst, e.tag, n, e.cnt);
    end
    checks++;
    assert ({c, b, r} === {e.c, e.b, e.r}) else begin
      errors++;
      $error("FAIL %s.%s c/b/r got=%b want=%b",
             inst, e.tag, {c, b, r}, {e.c, e.b, e.r});
    end
  endtask

  // Advance one clock and score whatever was pushed for it.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("A", e, cnt_a, c_a, b_a, r_a);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("B", e, cnt_b, c_b, b_b, r_b);
    end
  endtask

  initial begin
    int  n;
    bit  ar;
`ifdef CONTADOR_AUTOREPEAT_EN
    ar = 1'b1;
`else
    ar = 1'b0;
`endif
    reset       = 1'b1;
    en_count    = 4'd7;
    enUP_a      = 1'b0;
    enDOWN_a    = 1'b0;
    load_en_a   = 1'b0;
    load_data_a = 8'd0;
    enUP_b      = 1'b0;
    enDOWN_b    = 1'b0;
    load_en_b   = 1'b0;
    load_data_b = 8'd0;

    @(posedge clk);
    #1;
    push_a("reset", 1, 0, 0, 0);
    push_b("reset", 0, 0, 0, 0);
    cyc();
    reset = 1'b0;

    for (int i = 1; i <= 7; i++) begin
      n = (i == 7) ? 1 : i + 1;
      enUP_a = 1'b1;
      push_a("up_wrap", n, (i == 7), 0, 0);
      cyc();
      enUP_a = 1'b0;
      push_a("up_rel", n, 0, 0, 0);
      cyc();
    end

    reset = 1'b1;
    push_a("reset2", 1, 0, 0, 0);
    cyc();
    reset = 1'b0;

    enDOWN_a = 1'b1;
    push_a("dn_wrap", 7, 0, 1, 0);
    cyc();
    enDOWN_a = 1'b0;
    push_a("dn_rel", 7, 0, 0, 0);
    cyc();

    en_count = SEL_HORA;
    enUP_a = 1'b1;
    push_a("disabled", 7, 0, 0, 0);
    cyc();
    enUP_a = 1'b0;
    push_a("disabled_rel", 7, 0, 0, 0);
    cyc();
    en_count = SEL_DIA_SEM;

    enUP_a   = 1'b1;
    enDOWN_a = 1'b1;
    push_a("both", 7, 0, 0, 0);
    cyc();
    enUP_a   = 1'b0;
    enDOWN_a = 1'b0;
    push_a("both_rel", 7, 0, 0, 0);
    cyc();

    enDOWN_a = 1'b1;
    push_a("dn", 6, 0, 0, 0);
    cyc();
    enDOWN_a = 1'b0;
    push_a("dn_rel2", 6, 0, 0, 0);
    cyc();

    enUP_a = 1'b1;
    for (int k = 0; k < 100; k++) begin
      push_a("held", 7, 0, 0, 0);
      cyc();
    end
    enUP_a = 1'b0;
    push_a("held_rel", 7, 0, 0, 0);
    cyc();

    load_en_b   = 1'b1;
    load_data_b = 8'd45;
    push_b("load45", 45, 0, 0, 0);
    cyc();
    load_data_b = 8'd60;
    push_b("load60", 0, 0, 0, 1);
    cyc();
    load_en_b = 1'b0;
    push_b("load_idle", 0, 0, 0, 0);
    cyc();

    load_en_b   = 1'b1;
    load_data_b = 8'd20;
    enUP_b      = 1'b1;
    push_b("load_wins", 20, 0, 0, 0);
    cyc();
    load_en_b = 1'b0;
    enUP_b    = 1'b0;
    push_b("load_rel", 20, 0, 0, 0);
    cyc();

    n = 20;
    enUP_b = 1'b1;
    for (int k = 0; k <= 22; k++) begin
      if (k == 0 || (ar && k >= 10 && (k - 10) % 4 == 0))
        n++;
      push_b("rpt", n, 0, 0, 0);
      cyc();
    end
    enUP_b = 1'b0;
    push_b("rpt_rel", ar ? 25 : 21, 0, 0, 0);
    cyc();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/contador_ad_mod.md
Name: contador_ad_mod

Overview:
Generic up/down modular counter for the RTC time/date edit path. It replaces the fixed per-field counters (day-of-week, hours, minutes, date, month, year) with a single parametrised block. Each instance is enabled when the field selector equals its SEL_ID. It edge-detects the up/down keys, wraps inside [MIN, MAX], supports a parallel load from the RTC read-back, and flags wrap events.

Parameters:
N, 8, counter/output width in bits (3..8)
MIN, 0, lowest count value
MAX, 59, highest count value (MIN < MAX < 2**N)
SEL_ID, 7, en_count value that enables this instance
OUT_OFFSET, 0, constant added to the count for count_data (day-of-week uses MIN=0, MAX=6, OUT_OFFSET=1)
HOLD_CYC, 50000000, key-held cycles before autorepeat starts (optional feature only)
RPT_CYC, 10000000, cycles between repeat ticks (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
en_count  in  4  field selector from the edit FSM
enUP  in  1  up key, level, already debounced
enDOWN  in  1  down key, level, already debounced
load_en  in  1  one-cycle load strobe
load_data  in  N  value to load (binary)
count_data  out  N  q_act + OUT_OFFSET, truncated to N bits
carry  out  1  one-cycle pulse on up-wrap MAX->MIN
borrow  out  1  one-cycle pulse on down-wrap MIN->MAX
range_err  out  1  one-cycle pulse when load_data is out of range

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values:
  - q_act = MIN, so count_data = MIN+OFFSET.
  - enUP_reg = enDOWN_reg = 0.
  - carry = borrow = range_err = 0.
- Edge detection:
  - up_tick = enUP & ~enUP_reg; down_tick = enDOWN & ~enDOWN_reg.
  - Both registers are sampled every cycle, including while reset or disabled.
- active = (en_count == SEL_ID).
- Next-state priority, all evaluated in the same cycle and registered on the next clk edge:
  1. reset: load reset values.
  2. load_en (ignores active):
     - If MIN <= load_data <= MAX: q_act = load_data.
     - Otherwise: q_act = MIN and range_err pulses.
  3. active & up_tick & down_tick: hold, no pulses.
  4. active & up_tick:
     - If q_act == MAX: q_act = MIN, carry = 1.
     - Else: q_act + 1.
  5. active & down_tick:
     - If q_act == MIN: q_act = MAX, borrow = 1.
     - Else: q_act - 1.
  6. Otherwise: hold.
- Wrap happens only on a tick. There is no spontaneous wrap when idle.
- Out-of-range q_act is unreachable.
- Latency: enUP rises in cycle t, count_data shows the new value from cycle t+1. carry/borrow/range_err are registered and coincide with the updated count.
- A key held across a change of en_count does not produce a tick on the newly selected instance, because edge registers track the key continuously.
- Arithmetic: all compares at N bits. count_data adder is N bits wide and truncates.

Optional Feature:
Macro CONTADOR_AUTOREPEAT_EN.
- Defined:
  - A per-key hold counter (width ceil(log2(HOLD_CYC+1))) runs while the key is high and active.
  - Once HOLD_CYC cycles are reached, an extra tick is generated every RPT_CYC cycles until the key is released.
  - The counter clears on release, reset, or !active.
  - If both keys are held, neither repeats.
- Not defined:
  - Only rising-edge ticks exist.
  - The hold counters and HOLD_CYC/RPT_CYC logic are absent; the parameters are ignored.

Decomposition:
- Package contador_pkg holds:
  - Field SEL_ID constants: SEL_SEG, SEL_MIN, SEL_HORA, SEL_DIA, SEL_MES, SEL_ANO, SEL_DIA_SEM=7.
  - Per-field MIN/MAX constants.
  - The en_count width (4).
- One sub-module, detector_flanco_rpt:
  - Implements edge register plus optional autorepeat timer for one key.
  - Outputs a tick.
  - Instantiated twice.

Test Plan:
1. Reset: with MIN=0, MAX=6, OFFSET=1, assert reset for 2 cycles -> count_data=1, all pulses 0.
2. Up wrap: with en_count=7, give 7 enUP pulses -> count_data 2,3,4,5,6,7,1, with carry high only on the 7th update.
3. Down wrap and disable:
   - From reset, one enDOWN pulse -> count_data=7 and borrow pulse.
   - With en_count=3, enUP pulse -> no change.
4. Simultaneous keys and held key:
   - enUP and enDOWN rising in the same cycle -> no change.
   - enUP held 100 cycles (macro off) -> exactly one increment.
5. Load: with MIN=0, MAX=59:
   - load_data=45 -> count_data=45.
   - load_data=60 -> count_data=0 and range_err pulse.
   - load_en with a coincident up tick -> load wins.
6. Autorepeat: with macro on, HOLD_CYC=10, RPT_CYC=4, hold enUP 22 cycles -> increments at the edge, at +10, +14, +18, +22 (5 total).
